// File: rtl/pulse_mon_pkg.sv
// Shared types and default constants for the pulse_monitor health checker.
package pulse_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } mon_state_t;

    localparam int DEF_EXP_DURATION = 4;
    localparam int DEF_EXP_PERIOD   = 10;
    localparam int DEF_TOL          = 0;
    localparam int DEF_TIMEOUT      = 20;
    localparam int DEF_CNT_W        = 16;

    typedef struct packed {
        logic [DEF_CNT_W-1:0] duration;
        logic [DEF_CNT_W-1:0] period;
    } meas_t;

endpackage

// File: rtl/pulse_monitor_if.sv
// Stream input and measurement outputs of pulse_monitor.
// PULSE_MON_STATS_EN adds the meas_count/err_count statistics signals.
interface pulse_monitor_if
    import pulse_mon_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) ();

    logic             enable;
    logic             pulse_in;
    logic             meas_valid;
    logic [CNT_W-1:0] meas_duration;
    logic [CNT_W-1:0] meas_period;
    logic             duration_err;
    logic             period_err;
    logic             timeout_err;
    logic             locked;
`ifdef PULSE_MON_STATS_EN
    logic [15:0]      meas_count;
    logic [15:0]      err_count;
`endif

    modport master (
        input  enable, pulse_in,
        output meas_valid, meas_duration, meas_period,
        output duration_err, period_err, timeout_err, locked
`ifdef PULSE_MON_STATS_EN
        , output meas_count, err_count
`endif
    );

    modport slave (
        output enable, pulse_in,
        input  meas_valid, meas_duration, meas_period,
        input  duration_err, period_err, timeout_err, locked
`ifdef PULSE_MON_STATS_EN
        , input meas_count, err_count
`endif
    );

endinterface

// File: rtl/pulse_edge_detect.sv
// One-cycle delay of the pulse stream plus rise/fall strobes; RESET_VAL sets
// what the stream is assumed to have been before reset release.
module pulse_edge_detect #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic pulse_in,
    output logic rise,
    output logic fall
);

    logic pulse_q;

    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) pulse_q <= RESET_VAL;
        else       pulse_q <= pulse_in;
    end

    assign rise = pulse_in & ~pulse_q;
    assign fall = ~pulse_in & pulse_q;

endmodule

// File: rtl/pulse_monitor.sv
// Measures high time and period of pulse_in and flags deviations and missing edges.
// Define PULSE_MON_STATS_EN to add the meas_count/err_count statistics counters.
module pulse_monitor
    import pulse_mon_pkg::*;
#(
    parameter int EXP_DURATION = DEF_EXP_DURATION,
    parameter int EXP_PERIOD   = DEF_EXP_PERIOD,
    parameter int TOL          = DEF_TOL,
    parameter int TIMEOUT      = DEF_TIMEOUT,
    parameter int CNT_W        = DEF_CNT_W
) (
    input logic             clk,
    input logic             reset,
    pulse_monitor_if.master bus
);

    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
    localparam logic [CNT_W-1:0] EXP_D_C   = CNT_W'(EXP_DURATION);
    localparam logic [CNT_W-1:0] EXP_P_C   = CNT_W'(EXP_PERIOD);
    localparam logic [CNT_W-1:0] TOL_C     = CNT_W'(TOL);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    if (EXP_DURATION >= EXP_PERIOD) begin : g_bad_duration
        $error("pulse_monitor: EXP_DURATION must be smaller than EXP_PERIOD");
    end
    if (TIMEOUT <= EXP_PERIOD) begin : g_bad_timeout
        $error("pulse_monitor: TIMEOUT must exceed EXP_PERIOD");
    end
    if (64'(TIMEOUT) >= (64'd1 << CNT_W)) begin : g_bad_width
        $error("pulse_monitor: TIMEOUT does not fit in CNT_W bits");
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + ONE_C;
    endfunction

    function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                  input logic [CNT_W-1:0] b);
        return (a > b) ? a - b : b - a;
    endfunction

    logic             rise, fall;
    mon_state_t       state, state_d;
    logic [CNT_W-1:0] hi_cnt, hi_d, per_cnt, per_d;
    logic             emit, tmo, dur_bad, per_bad;

    logic             meas_valid_q, duration_err_q, period_err_q, timeout_err_q, locked_q;
    logic [CNT_W-1:0] meas_duration_q, meas_period_q;

    pulse_edge_detect #(.RESET_VAL(1'b1)) u_edge (
        .clk      (clk),
        .reset    (reset),
        .pulse_in (bus.pulse_in),
        .rise     (rise),
        .fall     (fall)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_d = state;
        hi_d    = hi_cnt;
        per_d   = per_cnt;
        emit    = 1'b0;
        tmo     = 1'b0;
        if (!bus.enable) begin
            state_d = IDLE;
            hi_d    = '0;
            per_d   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (rise) begin
                        state_d = HIGH;
                        hi_d    = ONE_C;
                        per_d   = ONE_C;
                    end
                end
                HIGH: begin
                    if (per_cnt >= TIMEOUT_C) begin
                        tmo     = 1'b1;
                        state_d = IDLE;
                        hi_d    = '0;
                        per_d   = '0;
                    end else if (fall) begin
                        per_d   = sat_inc(per_cnt);
                        state_d = LOW;
                    end else begin
                        hi_d    = sat_inc(hi_cnt);
                        per_d   = sat_inc(per_cnt);
                    end
                end
                LOW: begin
                    // The closing rise outranks a timeout reached in the same cycle.
                    if (rise) begin
                        emit    = 1'b1;
                        state_d = HIGH;
                        hi_d    = ONE_C;
                        per_d   = ONE_C;
                    end else if (per_cnt >= TIMEOUT_C) begin
                        tmo     = 1'b1;
                        state_d = IDLE;
                        hi_d    = '0;
                        per_d   = '0;
                    end else begin
                        per_d   = sat_inc(per_cnt);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign dur_bad = abs_diff(hi_cnt, EXP_D_C) > TOL_C;
    assign per_bad = abs_diff(per_cnt, EXP_P_C) > TOL_C;

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_cnt          <= '0;
            per_cnt         <= '0;
            meas_valid_q    <= 1'b0;
            meas_duration_q <= '0;
            meas_period_q   <= '0;
            duration_err_q  <= 1'b0;
            period_err_q    <= 1'b0;
            timeout_err_q   <= 1'b0;
            locked_q        <= 1'b0;
        end else begin
            hi_cnt         <= hi_d;
            per_cnt        <= per_d;
            meas_valid_q   <= emit;
            timeout_err_q  <= tmo;
            duration_err_q <= emit & dur_bad;
            period_err_q   <= emit & per_bad;
            if (emit) begin
                meas_duration_q <= hi_cnt;
                meas_period_q   <= per_cnt;
                locked_q        <= ~(dur_bad | per_bad);
            end else if (tmo || !bus.enable) begin
                locked_q        <= 1'b0;
            end
        end
    end

    assign bus.meas_valid    = meas_valid_q;
    assign bus.meas_duration = meas_duration_q;
    assign bus.meas_period   = meas_period_q;
    assign bus.duration_err  = duration_err_q;
    assign bus.period_err    = period_err_q;
    assign bus.timeout_err   = timeout_err_q;
    assign bus.locked        = locked_q;

`ifdef PULSE_MON_STATS_EN
    logic [15:0] meas_count_q, err_count_q;

    // Events only occur while enabled, so both counters hold while enable is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            meas_count_q <= '0;
            err_count_q  <= '0;
        end else begin
            if (emit && !(&meas_count_q))
                meas_count_q <= meas_count_q + 16'd1;
            if (((emit && (dur_bad || per_bad)) || tmo) && !(&err_count_q))
                err_count_q <= err_count_q + 16'd1;
        end
    end

    assign bus.meas_count = meas_count_q;
    assign bus.err_count  = err_count_q;
`endif

endmodule

// File: tb/tb_pulse_monitor.sv
// Scoreboard bench for pulse_monitor: two instances (TOL=0, TOL=1) share one stimulus stream.
// Build with PULSE_MON_STATS_EN defined to also check meas_count/err_count.
module tb_pulse_monitor;
    import pulse_mon_pkg::*;

    localparam int EXP_D = 4;
    localparam int EXP_P = 10;
    localparam int TMO   = 20;

    typedef struct {
        bit    is_tmo;
        meas_t m;
        bit    derr;
        bit    perr;
        bit    lock;
    } exp_t;

    logic clk;
    logic reset;
    logic enable;
    logic pulse_in;

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_on  = 0;

    exp_t q0[$];
    exp_t q1[$];

    // Reference model: tracks the cycle index of the opening rise and the fall.
    bit armed;
    bit p_prev;
    int cyc;
    int r_cyc;
    int f_cyc;
    int exp_dur;
    int exp_per;
    bit exp_lock [2];
    int exp_mcnt;
    int exp_ecnt [2];

    pulse_monitor_if #(.CNT_W(16)) bus0 ();
    pulse_monitor_if #(.CNT_W(16)) bus1 ();

    assign bus0.enable   = enable;
    assign bus0.pulse_in = pulse_in;
    assign bus1.enable   = enable;
    assign bus1.pulse_in = pulse_in;

    pulse_monitor #(.EXP_DURATION(EXP_D), .EXP_PERIOD(EXP_P), .TOL(0), .TIMEOUT(TMO), .CNT_W(16))
        dut0 (.clk(clk), .reset(reset), .bus(bus0));

    pulse_monitor #(.EXP_DURATION(EXP_D), .EXP_PERIOD(EXP_P), .TOL(1), .TIMEOUT(TMO), .CNT_W(16))
        dut1 (.clk(clk), .reset(reset), .bus(bus1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    task automatic push_exp(input int k, input exp_t e);
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic pop_exp(input int k, output bit ok, output exp_t e);
        ok = 1'b0;
        e  = '{default: 0};
        if (k == 0 && q0.size() > 0) begin
            e  = q0.pop_front();
            ok = 1'b1;
        end else if (k == 1 && q1.size() > 0) begin
            e  = q1.pop_front();
            ok = 1'b1;
        end
    endtask

    // One clock of the behavioural model for the inputs sampled at the coming edge.
    task automatic model(input bit p, input bit e, input bit r);
        bit   rise, fall;
        exp_t ev;
        int   dur, per, tol;
        if (r) begin
            armed    = 1'b0;
            p_prev   = 1'b1;
            exp_dur  = 0;
            exp_per  = 0;
            exp_mcnt = 0;
            for (int k = 0; k < 2; k++) begin
                exp_lock[k] = 1'b0;
                exp_ecnt[k] = 0;
            end
            cyc++;
            return;
        end
        rise = p && !p_prev;
        fall = !p && p_prev;
        if (!e) begin
            armed = 1'b0;
            for (int k = 0; k < 2; k++) exp_lock[k] = 1'b0;
        end else if (armed && rise) begin
            dur = f_cyc - r_cyc;
            per = cyc - r_cyc;
            exp_dur = dur;
            exp_per = per;
            exp_mcnt++;
            for (int k = 0; k < 2; k++) begin
                tol           = k;
                ev.is_tmo     = 1'b0;
                ev.m.duration = 16'(dur);
                ev.m.period   = 16'(per);
                ev.derr       = absd(dur, EXP_D) > tol;
                ev.perr       = absd(per, EXP_P) > tol;
                ev.lock       = !(ev.derr || ev.perr);
                exp_lock[k]   = ev.lock;
                if (!ev.lock) exp_ecnt[k]++;
                push_exp(k, ev);
            end
            r_cyc = cyc;
        end else if (armed && (cyc - r_cyc) >= TMO) begin
            armed = 1'b0;
            for (int k = 0; k < 2; k++) begin
                ev          = '{default: 0};
                ev.is_tmo   = 1'b1;
                exp_lock[k] = 1'b0;
                exp_ecnt[k]++;
                push_exp(k, ev);
            end
        end else if (!armed && rise) begin
            armed = 1'b1;
            r_cyc = cyc;
        end else if (armed && fall) begin
            f_cyc = cyc;
        end
        p_prev = p;
        cyc++;
    endtask

    task automatic step(input bit p, input bit e, input bit r);
        @(negedge clk);
        #1;
        pulse_in = p;
        enable   = e;
        reset    = r;
        model(p, e, r);
        if (r) mon_on = 1'b1;
    endtask

    task automatic pulses(input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < hi; j++) step(1'b1, 1'b1, 1'b0);
            for (int j = 0; j < lo; j++) step(1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic mon_check(input int k, input logic mv, input logic [15:0] md,
                             input logic [15:0] mp, input logic de, input logic pe,
                             input logic te, input logic lk);
        exp_t e;
        bit   ok;
        if (mv || te) begin
            pop_exp(k, ok, e);
            if (!ok) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected[%0d]: actual meas_valid=%0b timeout_err=%0b, required no strobe",
                         k, mv, te);
            end else begin
                check($sformatf("strobe_kind[%0d]", k), 32'({mv, te}), e.is_tmo ? 32'd1 : 32'd2);
                if (mv && !e.is_tmo) begin
                    check($sformatf("meas_duration[%0d]", k), 32'(md), 32'(e.m.duration));
                    check($sformatf("meas_period[%0d]", k), 32'(mp), 32'(e.m.period));
                    check($sformatf("duration_err[%0d]", k), 32'(de), 32'(e.derr));
                    check($sformatf("period_err[%0d]", k), 32'(pe), 32'(e.perr));
                end
            end
        end
        if (!mv) check($sformatf("err_flags_unqualified[%0d]", k), 32'({de, pe}), 32'd0);
        check($sformatf("hold_duration[%0d]", k), 32'(md), exp_dur);
        check($sformatf("hold_period[%0d]", k), 32'(mp), exp_per);
        check($sformatf("locked[%0d]", k), 32'(lk), 32'(exp_lock[k]));
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            mon_check(0, bus0.meas_valid, bus0.meas_duration, bus0.meas_period,
                      bus0.duration_err, bus0.period_err, bus0.timeout_err, bus0.locked);
            mon_check(1, bus1.meas_valid, bus1.meas_duration, bus1.meas_period,
                      bus1.duration_err, bus1.period_err, bus1.timeout_err, bus1.locked);
`ifdef PULSE_MON_STATS_EN
            check("meas_count[0]", 32'(bus0.meas_count), exp_mcnt);
            check("meas_count[1]", 32'(bus1.meas_count), exp_mcnt);
            check("err_count[0]", 32'(bus0.err_count), exp_ecnt[0]);
            check("err_count[1]", 32'(bus1.err_count), exp_ecnt[1]);
`endif
        end
    end

    initial begin
        int hi, lo;
        pulse_in = 1'b1;
        enable   = 1'b1;
        reset    = 1'b1;
        cyc      = 0;

        // Pulse already high across reset release: not a rise.
        repeat (3) step(1'b1, 1'b1, 1'b1);
        check("reset_outputs", 32'({bus0.meas_valid, bus0.timeout_err, bus0.locked,
                                    bus0.duration_err, bus0.period_err}), 32'd0);
        check("reset_meas_values", 32'({bus0.meas_duration, bus0.meas_period}), 32'd0);
        repeat (3) step(1'b1, 1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b1, 1'b0);

        // Ideal 4/10 stream.
        pulses(4, 6, 6);
        check("ideal_locked", 32'(bus0.locked), 32'd1);

        // 5-high / 10-period: error only with TOL=0.
        pulses(5, 5, 4);
        check("wide_locked_tol0", 32'(bus0.locked), 32'd0);
        check("wide_locked_tol1", 32'(bus1.locked), 32'd1);
        pulses(4, 6, 2);

        // Period exactly at TIMEOUT is measured; one longer times out.
        pulses(4, 16, 1);
        pulses(4, 17, 1);
        pulses(4, 6, 2);

        // Stuck high, then idle low, then stuck low from an active period.
        pulses(25, 25, 1);
        pulses(4, 25, 1);
        pulses(4, 6, 3);

        // Reset mid-LOW.
        pulses(4, 3, 1);
        repeat (2) step(1'b0, 1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b1, 1'b0);
        pulses(4, 6, 4);

        // Enable dropped mid-LOW: IDLE, measurements held.
        repeat (4) step(1'b1, 1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        check("en_low_locked", 32'(bus0.locked), 32'd0);
        check("en_low_hold_duration", 32'(bus0.meas_duration), 32'd4);
        check("en_low_hold_period", 32'(bus0.meas_period), 32'd10);
        repeat (2) step(1'b0, 1'b1, 1'b0);
        pulses(4, 6, 4);

        // Randomised pulse widths with occasional enable drops.
        for (int i = 0; i < 80; i++) begin
            hi = int'($urandom_range(1, 8));
            lo = int'($urandom_range(1, 16));
            pulses(hi, lo, 1);
            if ($urandom_range(0, 9) == 0) repeat (2) step(1'b0, 1'b0, 1'b0);
        end

`ifdef PULSE_MON_STATS_EN
        // Three good periods followed by one timeout from a fresh reset.
        repeat (2) step(1'b0, 1'b1, 1'b1);
        pulses(4, 6, 3);
        pulses(25, 1, 1);
        repeat (2) step(1'b0, 1'b1, 1'b0);
        check("stats_meas_count", 32'(bus0.meas_count), 32'd3);
        check("stats_err_count", 32'(bus0.err_count), 32'd1);
`endif

        // Closing rise, then let the last strobe drain.
        step(1'b1, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b0);
        check("sb_drained[0]", 32'(q0.size()), 32'd0);
        check("sb_drained[1]", 32'(q1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
